// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle controller, its datapath and the bench.
package ctrl_pkg;

    typedef enum logic [3:0] {
        ST_START    = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_MEMADR   = 4'd3,
        ST_MEMREAD  = 4'd4,
        ST_MEMWB    = 4'd5,
        ST_MEMWRITE = 4'd6,
        ST_EXEC_R   = 4'd7,
        ST_ALUWB    = 4'd8,
        ST_BRANCH   = 4'd9,
        ST_TRAP     = 4'd10
    } state_t;

    // Major opcodes handled by the core
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_SD = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;
    localparam logic [6:0] OP_R  = 7'b0110011;

    // ALU operand A select
    localparam logic [1:0] SRC_A_PC    = 2'b00;
    localparam logic [1:0] SRC_A_OLDPC = 2'b01;
    localparam logic [1:0] SRC_A_RS1   = 2'b10;

    // ALU operand B select
    localparam logic [1:0] SRC_B_RS2   = 2'b00;
    localparam logic [1:0] SRC_B_FOUR  = 2'b01;
    localparam logic [1:0] SRC_B_IMM   = 2'b10;

    // ALU operation
    localparam logic [1:0] ALU_ADD     = 2'b00;
    localparam logic [1:0] ALU_SUB     = 2'b01;
    localparam logic [1:0] ALU_FUNCT   = 2'b10;

    // Write-back / PC source select
    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_MEMDATA = 2'b01;
    localparam logic [1:0] RES_ALU     = 2'b10;

    // Trap causes
    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_BUS     = 2'b10;

endpackage

// File: rtl/ctrl_opdec.sv
// Combinational classification of the major opcode.
module ctrl_opdec
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output logic       is_ld,
    output logic       is_sd,
    output logic       is_br,
    output logic       is_r,
    output logic       illegal
);

    // One-hot class flags; anything unrecognised is illegal
    always_comb begin
        is_ld   = 1'b0;
        is_sd   = 1'b0;
        is_br   = 1'b0;
        is_r    = 1'b0;
        illegal = 1'b0;
        case (opcode)
            OP_LD:   is_ld   = 1'b1;
            OP_SD:   is_sd   = 1'b1;
            OP_BR:   is_br   = 1'b1;
            OP_R:    is_r    = 1'b1;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM: sequences fetch/decode/execute for ld, sd, beq and
// R-type, handshakes with the unified memory and traps on illegal opcodes or
// memory timeouts.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_we,
    output logic       pc_we,
    output logic       reg_we,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] result_src,
    output logic       instr_done,
    output logic       trap,
    output logic [1:0] trap_cause
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] TMO_ONE  = CW'(1);
    localparam logic [CW-1:0] TMO_ZERO = CW'(0);

    state_t          state_q, state_d;
    logic [CW-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic [1:0]      trap_cause_q, trap_cause_d;
    logic            is_ld_s, is_sd_s, is_br_s, is_r_s, illegal_s;
    logic            tmo_last_s;

    ctrl_opdec u_opdec (
        .opcode  (opcode),
        .is_ld   (is_ld_s),
        .is_sd   (is_sd_s),
        .is_br   (is_br_s),
        .is_r    (is_r_s),
        .illegal (illegal_s)
    );

    // Last permitted wait cycle: another miss here means a bus timeout
    assign tmo_last_s = (tmo_cnt_q == TMO_LAST);

    // State, timeout counter and trap cause registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_START;
            tmo_cnt_q    <= TMO_ZERO;
            trap_cause_q <= CAUSE_NONE;
        end else begin
            state_q      <= state_d;
            tmo_cnt_q    <= tmo_cnt_d;
            trap_cause_q <= trap_cause_d;
        end
    end

    // Next-state sequencing and trap cause capture
    always_comb begin
        state_d      = state_q;
        trap_cause_d = trap_cause_q;
        case (state_q)
            ST_START: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (mem_ready) begin
                    state_d = ST_DECODE;
                end else if (tmo_last_s) begin
                    state_d      = ST_TRAP;
                    trap_cause_d = CAUSE_BUS;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_DECODE: begin
                if (illegal_s) begin
                    state_d      = ST_TRAP;
                    trap_cause_d = CAUSE_ILLEGAL;
                end else if (is_ld_s || is_sd_s) begin
                    state_d = ST_MEMADR;
                end else if (is_r_s) begin
                    state_d = ST_EXEC_R;
                end else if (is_br_s) begin
                    state_d = ST_BRANCH;
                end else begin
                    state_d      = ST_TRAP;
                    trap_cause_d = CAUSE_ILLEGAL;
                end
            end
            ST_MEMADR: begin
                if (is_sd_s) begin
                    state_d = ST_MEMWRITE;
                end else begin
                    state_d = ST_MEMREAD;
                end
            end
            ST_MEMREAD: begin
                if (mem_ready) begin
                    state_d = ST_MEMWB;
                end else if (tmo_last_s) begin
                    state_d      = ST_TRAP;
                    trap_cause_d = CAUSE_BUS;
                end else begin
                    state_d = ST_MEMREAD;
                end
            end
            ST_MEMWB: begin
                state_d = ST_FETCH;
            end
            ST_MEMWRITE: begin
                if (mem_ready) begin
                    state_d = ST_FETCH;
                end else if (tmo_last_s) begin
                    state_d      = ST_TRAP;
                    trap_cause_d = CAUSE_BUS;
                end else begin
                    state_d = ST_MEMWRITE;
                end
            end
            ST_EXEC_R: begin
                state_d = ST_ALUWB;
            end
            ST_ALUWB: begin
                state_d = ST_FETCH;
            end
            ST_BRANCH: begin
                state_d = ST_FETCH;
            end
            ST_TRAP: begin
                state_d = ST_TRAP;
            end
            default: begin
                state_d = ST_START;
            end
        endcase
    end

    // Wait-state counter: counts unanswered requests, cleared on any state change
    always_comb begin
        if (state_d != state_q) begin
            tmo_cnt_d = TMO_ZERO;
        end else if (mem_req && !mem_ready) begin
            tmo_cnt_d = tmo_cnt_q + TMO_ONE;
        end else begin
            tmo_cnt_d = tmo_cnt_q;
        end
    end

    // Moore output decode; FETCH passes mem_ready through to the IR/PC strobes
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        reg_we     = 1'b0;
        alu_src_a  = SRC_A_PC;
        alu_src_b  = SRC_B_RS2;
        alu_op     = ALU_ADD;
        result_src = RES_ALUOUT;
        instr_done = 1'b0;
        trap       = 1'b0;
        trap_cause = CAUSE_NONE;
        case (state_q)
            ST_START: begin
                mem_req = 1'b0;
            end
            ST_FETCH: begin
                mem_req    = 1'b1;
                iord       = 1'b0;
                ir_we      = mem_ready;
                pc_we      = mem_ready;
                alu_src_a  = SRC_A_PC;
                alu_src_b  = SRC_B_FOUR;
                alu_op     = ALU_ADD;
                result_src = RES_ALU;
            end
            ST_DECODE: begin
                alu_src_a = SRC_A_OLDPC;
                alu_src_b = SRC_B_IMM;
                alu_op    = ALU_ADD;
            end
            ST_MEMADR: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
                alu_op    = ALU_ADD;
            end
            ST_MEMREAD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            ST_MEMWB: begin
                reg_we     = 1'b1;
                result_src = RES_MEMDATA;
                instr_done = 1'b1;
            end
            ST_MEMWRITE: begin
                mem_req    = 1'b1;
                mem_we     = 1'b1;
                iord       = 1'b1;
                instr_done = mem_ready;
            end
            ST_EXEC_R: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_RS2;
                alu_op    = ALU_FUNCT;
            end
            ST_ALUWB: begin
                reg_we     = 1'b1;
                result_src = RES_ALUOUT;
                instr_done = 1'b1;
            end
            ST_BRANCH: begin
                alu_src_a  = SRC_A_RS1;
                alu_src_b  = SRC_B_RS2;
                alu_op     = ALU_SUB;
                result_src = RES_ALUOUT;
                pc_we      = zero;
                instr_done = 1'b1;
            end
            ST_TRAP: begin
                trap       = 1'b1;
                trap_cause = trap_cause_q;
            end
            default: begin
                trap = 1'b0;
            end
        endcase
    end

endmodule
